// File: rtl/data_ram_slave_pkg.sv
// data_ram_slave_pkg: shared widths, FSM encoding and wait-counter width for the data-RAM responder
package data_ram_slave_pkg;
  localparam int DATA_BUS = 32;
  localparam int ADDR_BUS = 32;
  localparam int RAM_WORD_BYTES = 4;
  localparam int WAIT_W = 4;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/data_ram_slave_ram_byte_array.sv
// data_ram_slave_ram_byte_array: four byte-lane memories with per-lane synchronous write and synchronous read
module data_ram_slave_ram_byte_array
  import data_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic [RAM_WORD_BYTES-1:0] we,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_BUS-1:0]       wdata,
  output logic [DATA_BUS-1:0]       rdata
);
  for (genvar g = 0; g < RAM_WORD_BYTES; g++) begin : g_lane
    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] q;
    // each lane writes only under its own strobe; read data is registered per lane
    always_ff @(posedge clk) begin
      if (we[g]) mem[addr] <= wdata[8*g +: 8];
      if (re) q <= mem[addr];
    end
    assign rdata[8*g +: 8] = q;
  end
endmodule

// File: rtl/data_ram_slave.sv
// data_ram_slave: MEM-stage data RAM responder with wait states and stall; DATA_RAM_RANGE_CHECK_EN enables out-of-range faulting
module data_ram_slave
  import data_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ram_en,
  input  logic [RAM_WORD_BYTES-1:0] ram_write_en,
  input  logic [ADDR_BUS-1:0]       ram_addr,
  input  logic [DATA_BUS-1:0]       ram_write_data,
  output logic [DATA_BUS-1:0]       ram_read_data,
  output logic                      ram_stall,
  output logic                      ram_fault
);
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);
  state_t                    state;
  logic [WAIT_W-1:0]         cnt;
  logic [ADDR_BUS-1:0]       req_addr;
  logic [RAM_WORD_BYTES-1:0] req_we;
  logic [DATA_BUS-1:0]       req_wdata;
  logic                      rd_valid;
  logic                      accept;
  logic                      commit;
  logic                      oor;
  logic [ADDR_BUS-1:0]       cur_addr;
  logic [RAM_WORD_BYTES-1:0] cur_we;
  logic [DATA_BUS-1:0]       cur_wdata;
  logic [DATA_BUS-1:0]       arr_rdata;
  logic                      unused_addr;
  assign accept = state == IDLE && ram_en;
  // with zero wait states the commit edge is the accept edge, so the live request is used directly
  assign commit = rst && ((accept && WAIT_LD == '0) || (state == BUSY && cnt == WAIT_W'(1)));
  assign cur_addr  = state == IDLE ? ram_addr : req_addr;
  assign cur_we    = state == IDLE ? ram_write_en : req_we;
  assign cur_wdata = state == IDLE ? ram_write_data : req_wdata;
`ifdef DATA_RAM_RANGE_CHECK_EN
  assign oor = |cur_addr[ADDR_BUS-1:ADDR_WIDTH+2];
`else
  assign oor = 1'b0;
`endif
  assign unused_addr = ^{cur_addr[1:0], cur_addr[ADDR_BUS-1:ADDR_WIDTH+2]};
  assign ram_stall = state == BUSY || accept;
  assign ram_read_data = rd_valid ? arr_rdata : '0;
  data_ram_slave_ram_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk  (clk),
    .we   (commit && !oor ? cur_we : '0),
    .re   (commit && cur_we == '0 && !oor),
    .addr (cur_addr[ADDR_WIDTH+1:2]),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );
  // request latch, wait counter, FSM and registered status; rd_valid masks the array output to zero after writes and faulting reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_we    <= '0;
      req_wdata <= '0;
      rd_valid  <= 1'b0;
      ram_fault <= 1'b0;
    end else begin
      state <= state == IDLE ? (ram_en ? (WAIT_LD == '0 ? DONE : BUSY) : IDLE)
             : state == BUSY ? (cnt == WAIT_W'(1) ? DONE : BUSY) : IDLE;
      cnt <= accept ? WAIT_LD : state == BUSY ? cnt - WAIT_W'(1) : cnt;
      ram_fault <= commit && oor;
      if (commit) rd_valid <= cur_we == '0 && !oor;
      if (accept) begin
        req_addr  <= ram_addr;
        req_we    <= ram_write_en;
        req_wdata <= ram_write_data;
      end
    end
  end
endmodule

// File: tb/tb_data_ram_slave.sv
// tb_data_ram_slave: directed checks of a 1-wait-state and a 0-wait-state data_ram_slave
module tb_data_ram_slave;
  logic        clk;
  logic        rst;
  logic        en    [2];
  logic [3:0]  we_s  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        fault [2];
  int total = 0;
  int bad = 0;

  data_ram_slave #(.ADDR_WIDTH(14), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ram_en(en[0]), .ram_write_en(we_s[0]), .ram_addr(addr[0]),
    .ram_write_data(wdata[0]), .ram_read_data(rdata[0]), .ram_stall(stall[0]), .ram_fault(fault[0])
  );
  data_ram_slave #(.ADDR_WIDTH(14), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ram_en(en[1]), .ram_write_en(we_s[1]), .ram_addr(addr[1]),
    .ram_write_data(wdata[1]), .ram_read_data(rdata[1]), .ram_stall(stall[1]), .ram_fault(fault[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc, output logic flt, output time td);
    @(negedge clk);
    en[d] = 1; we_s[d] = w; addr[d] = a; wdata[d] = wd;
    #1;
    cyc = 0;
    while (stall[d] && cyc < 20) begin
      cyc++;
      @(posedge clk); #1;
    end
    rd = rdata[d]; flt = fault[d]; td = $time;
    en[d] = 0; we_s[d] = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 0; we_s[d] = 0; addr[d] = 0; wdata[d] = 0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (stall[d] !== 1'b0 || rdata[d] !== 32'h0 || fault[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d got stall=%b rd=%h fault=%b want 0/0/0", d, stall[d], rdata[d], fault[d]);
      end
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_wait1;
    logic [31:0] rd; int cyc; logic flt; time td;
    access(1, 4'hF, 32'h100, 32'hDEADBEEF, rd, cyc, flt, td);
    total++;
    if (cyc !== 2 || rd !== 32'h0) begin
      bad++;
      $display("FAIL wait1_write got stall_cycles=%0d rd=%h want 2/00000000", cyc, rd);
    end
    access(1, 4'h0, 32'h100, 32'h0, rd, cyc, flt, td);
    total++;
    if (cyc !== 2 || rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wait1_read got stall_cycles=%0d rd=%h want 2/deadbeef", cyc, rd);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; int cyc; logic flt; time td;
    access(1, 4'hF, 32'h104, 32'h11223344, rd, cyc, flt, td);
    access(1, 4'b0010, 32'h104, 32'h0000AB00, rd, cyc, flt, td);
    access(1, 4'h0, 32'h104, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== 32'h1122AB44) begin
      bad++;
      $display("FAIL byte_lane1 got %h want 1122ab44", rd);
    end
    access(1, 4'b1001, 32'h104, 32'hEE0000FF, rd, cyc, flt, td);
    access(1, 4'h0, 32'h104, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== 32'hEE22ABFF) begin
      bad++;
      $display("FAIL byte_lane2 got %h want ee22abff", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int cyc; logic flt; time t0, t1, t2;
    access(0, 4'hF, 32'h40, 32'h00000055, rd, cyc, flt, t0);
    access(0, 4'h0, 32'h40, 32'h0, rd, cyc, flt, t0);
    total++;
    if (cyc !== 1 || rd !== 32'h55) begin
      bad++;
      $display("FAIL b2b_read1 got stall_cycles=%0d rd=%h want 1/00000055", cyc, rd);
    end
    access(0, 4'hF, 32'h40, 32'hA5A5A5A5, rd, cyc, flt, t1);
    total++;
    if (cyc !== 1 || rd !== 32'h0 || t1 - t0 !== 20) begin
      bad++;
      $display("FAIL b2b_write got stall_cycles=%0d rd=%h gap=%0t want 1/00000000/20", cyc, rd, t1 - t0);
    end
    access(0, 4'h0, 32'h40, 32'h0, rd, cyc, flt, t2);
    total++;
    if (cyc !== 1 || rd !== 32'hA5A5A5A5 || t2 - t1 !== 20) begin
      bad++;
      $display("FAIL b2b_read2 got stall_cycles=%0d rd=%h gap=%0t want 1/a5a5a5a5/20", cyc, rd, t2 - t1);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd; int cyc; logic flt; time td;
    access(1, 4'hF, 32'h200, 32'h0, rd, cyc, flt, td);
    access(1, 4'h0, 32'h100, 32'h0, rd, cyc, flt, td);
    @(negedge clk);
    en[1] = 1; we_s[1] = 4'hF; addr[1] = 32'h200; wdata[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    total++;
    if (stall[1] !== 1'b1 || rdata[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL busy_before_reset got stall=%b rd=%h want 1/deadbeef", stall[1], rdata[1]);
    end
    rst = 0;
    en[1] = 0; we_s[1] = 0;
    #1;
    total++;
    if (stall[1] !== 1'b0 || rdata[1] !== 32'h0 || fault[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got stall=%b rd=%h fault=%b want 0/0/0", stall[1], rdata[1], fault[1]);
    end
    @(negedge clk);
    rst = 1;
    access(1, 4'h0, 32'h200, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_aborted_write got %h want 00000000", rd);
    end
  endtask

  task automatic test_range;
    logic [31:0] rd; int cyc; logic flt; time td;
    logic [31:0] exp_w0, exp_hi;
    logic exp_f;
`ifdef DATA_RAM_RANGE_CHECK_EN
    exp_f = 1; exp_w0 = 32'h0BADC0DE; exp_hi = 32'h0;
`else
    exp_f = 0; exp_w0 = 32'h77777777; exp_hi = 32'h77777777;
`endif
    access(1, 4'hF, 32'h0, 32'h0BADC0DE, rd, cyc, flt, td);
    total++;
    if (flt !== 1'b0) begin
      bad++;
      $display("FAIL inrange_fault got %b want 0", flt);
    end
    access(1, 4'hF, 32'h0001_0000, 32'h77777777, rd, cyc, flt, td);
    total++;
    if (flt !== exp_f || cyc !== 2) begin
      bad++;
      $display("FAIL range_write got fault=%b stall_cycles=%0d want %b/2", flt, cyc, exp_f);
    end
    total++;
    if (fault[1] !== 1'b0) begin
      bad++;
      $display("FAIL fault_pulse_len got %b want 0", fault[1]);
    end
    access(1, 4'h0, 32'h0, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== exp_w0) begin
      bad++;
      $display("FAIL range_word0 got %h want %h", rd, exp_w0);
    end
    access(1, 4'h0, 32'h0001_0000, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== exp_hi || flt !== exp_f) begin
      bad++;
      $display("FAIL range_read got rd=%h fault=%b want %h/%b", rd, flt, exp_hi, exp_f);
    end
  endtask

  task automatic test_en_drop;
    logic [31:0] rd; int cyc; logic flt; time td;
    access(1, 4'hF, 32'h304, 32'h0F0F0F0F, rd, cyc, flt, td);
    @(negedge clk);
    en[1] = 1; we_s[1] = 4'hF; addr[1] = 32'h300; wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    en[1] = 0; addr[1] = 32'h304; wdata[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    total++;
    if (stall[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      bad++;
      $display("FAIL en_drop_done got stall=%b rd=%h want 0/00000000", stall[1], rdata[1]);
    end
    @(posedge clk); #1;
    total++;
    if (stall[1] !== 1'b0) begin
      bad++;
      $display("FAIL en_drop_idle got stall=%b want 0", stall[1]);
    end
    we_s[1] = 0;
    access(1, 4'h0, 32'h300, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== 32'h12345678) begin
      bad++;
      $display("FAIL en_drop_commit got %h want 12345678", rd);
    end
    access(1, 4'h0, 32'h304, 32'h0, rd, cyc, flt, td);
    total++;
    if (rd !== 32'h0F0F0F0F) begin
      bad++;
      $display("FAIL en_drop_ignored got %h want 0f0f0f0f", rd);
    end
  endtask

  initial begin
    test_reset;
    test_wait1;
    test_byte_lanes;
    test_back_to_back;
    test_reset_mid_access;
    test_range;
    test_en_drop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
